// File: rtl/grid_board_renderer.sv
// Registered VGA board renderer: classifies each pixel and holds board, cursor and turn state.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined.
module grid_board_renderer #(
   parameter int N            = 9,
   parameter int H_START      = 142,
   parameter int H_END        = 782,
   parameter int V_START      = 35,
   parameter int V_END        = 515,
   parameter int COLS         = 3,
   parameter int ROWS         = 3,
   parameter int CELL_W       = 212,
   parameter int CELL_H       = 159,
   parameter int MARK_OFF_X   = 75,
   parameter int MARK_OFF_Y   = 49,
   parameter int MARK_SIZE    = 61,
   parameter int CURSOR_W     = 2,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N:0]                   countH,
   input  logic [N:0]                   countV,
   input  logic                         move_left,
   input  logic                         move_right,
   input  logic                         move_up,
   input  logic                         move_down,
   input  logic                         select,
   input  logic                         clear,
   output logic                         vga_blank,
   output logic                         vga_sync,
   output logic [1:0]                   selector,
   output logic                         mark_player,
   output logic [$clog2(MARK_SIZE)-1:0] mark_x,
   output logic [$clog2(MARK_SIZE)-1:0] mark_y,
   output logic                         turn,
   output logic                         illegal,
   output logic                         board_full
);

   localparam int MW  = $clog2(MARK_SIZE);
   localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("BLINK_FRAMES must be at least 1");
   end

   logic [1:0]     board [ROWS][COLS];
   logic [CCW-1:0] cur_col;
   logic [RCW-1:0] cur_row;
   logic           pend_l, pend_r, pend_u, pend_d, pend_s;
   logic           frame_start, cursor_vis, full_c;

   assign frame_start = (countH == '0) && (countV == '0);

   // ---------------- coordinate stage ----------------
   int         xi, yi, col_i, row_i, lx, ly;
   logic       active, in_grid, is_line, in_mark, on_cursor;
   logic [1:0] cell_v, sel_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      xi     = int'(countH) - H_START;
      yi     = int'(countV) - V_START;
      active = (int'(countH) >= H_START) && (int'(countH) < H_END) &&
               (int'(countV) >= V_START) && (int'(countV) < V_END);
      col_i = 0;
      lx    = xi;
      for (int k = 1; k <= COLS; k++)
         if (xi >= k * CELL_W) begin
            col_i = k;
            lx    = xi - k * CELL_W;
         end
      row_i = 0;
      ly    = yi;
      for (int k = 1; k <= ROWS; k++)
         if (yi >= k * CELL_H) begin
            row_i = k;
            ly    = yi - k * CELL_H;
         end
      // col_i==COLS / row_i==ROWS marks the active strip beyond the board.
      in_grid = (col_i < COLS) && (row_i < ROWS);
      cell_v  = 2'b00;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (in_grid && r == row_i && c == col_i) cell_v = board[r][c];
      is_line = in_grid && (((lx == CELL_W - 1) && (col_i < COLS - 1)) ||
                            ((ly == CELL_H - 1) && (row_i < ROWS - 1)));
      in_mark = in_grid && (lx >= MARK_OFF_X) && (lx < MARK_OFF_X + MARK_SIZE) &&
                           (ly >= MARK_OFF_Y) && (ly < MARK_OFF_Y + MARK_SIZE);
      on_cursor = in_grid && cursor_vis && !is_line &&
                  (col_i == int'(cur_col)) && (row_i == int'(cur_row)) &&
                  ((lx < CURSOR_W) || (lx >= CELL_W - 1 - CURSOR_W) ||
                   (ly < CURSOR_W) || (ly >= CELL_H - 1 - CURSOR_W));
      if (!active)                      sel_d = 2'b01;
      else if (in_mark && cell_v != 0)  sel_d = 2'b11;
      else if (is_line || on_cursor)    sel_d = 2'b10;
      else                              sel_d = 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_blank   <= 1'b0;
         vga_sync    <= 1'b1;
         selector    <= 2'b01;
         mark_player <= 1'b0;
         mark_x      <= '0;
         mark_y      <= '0;
      end else begin
         vga_blank   <= active;
         vga_sync    <= !active;
         selector    <= sel_d;
         mark_player <= (sel_d == 2'b11) && (cell_v == 2'b10);
         mark_x      <= (sel_d == 2'b11) ? MW'(lx - MARK_OFF_X) : '0;
         mark_y      <= (sel_d == 2'b11) ? MW'(ly - MARK_OFF_Y) : '0;
      end
   end

   // ---------------- game state ----------------
   always_comb begin
      full_c = 1'b1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (board[r][c] == 2'b00) full_c = 1'b0;
   end

   // NOTE: the board is a handful of flops, not a RAM, so it is reset like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] <= 2'b00;
         cur_col    <= CCW'((COLS - 1) / 2);
         cur_row    <= RCW'((ROWS - 1) / 2);
         turn       <= 1'b0;
         illegal    <= 1'b0;
         board_full <= 1'b0;
         {pend_l, pend_r, pend_u, pend_d, pend_s} <= '0;
      end else begin
         illegal    <= 1'b0;
         board_full <= full_c;
         if (clear) begin
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++) board[r][c] <= 2'b00;
            cur_col <= CCW'((COLS - 1) / 2);
            cur_row <= RCW'((ROWS - 1) / 2);
            turn    <= 1'b0;
            {pend_l, pend_r, pend_u, pend_d, pend_s} <= '0;
         end else if (frame_start) begin
            if (pend_s) begin
               if (board[cur_row][cur_col] == 2'b00) begin
                  board[cur_row][cur_col] <= turn ? 2'b10 : 2'b01;
                  turn <= !turn;
               end else begin
                  illegal <= 1'b1;
               end
            end
            if (pend_l && !pend_r)
               cur_col <= (cur_col == '0) ? CCW'(COLS - 1) : cur_col - 1'b1;
            else if (pend_r && !pend_l)
               cur_col <= (cur_col == CCW'(COLS - 1)) ? '0 : cur_col + 1'b1;
            if (pend_u && !pend_d)
               cur_row <= (cur_row == '0) ? RCW'(ROWS - 1) : cur_row - 1'b1;
            else if (pend_d && !pend_u)
               cur_row <= (cur_row == RCW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
            // Pulses landing on the commit cycle itself wait for the next frame.
            {pend_l, pend_r, pend_u, pend_d, pend_s} <=
               {move_left, move_right, move_up, move_down, select};
         end else begin
            pend_l <= pend_l | move_left;
            pend_r <= pend_r | move_right;
            pend_u <= pend_u | move_up;
            pend_d <= pend_d | move_down;
            pend_s <= pend_s | select;
         end
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BW-1:0] blink_cnt;
   logic          cursor_hidden, moved;

   assign moved      = frame_start && ((pend_l ^ pend_r) || (pend_u ^ pend_d));
   assign cursor_vis = !cursor_hidden;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt     <= '0;
         cursor_hidden <= 1'b0;
      end else if (clear || moved) begin
         blink_cnt     <= '0;
         cursor_hidden <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt     <= '0;
            cursor_hidden <= !cursor_hidden;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`else
   assign cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_grid_board_renderer.sv
// Self-checking bench for grid_board_renderer: pixel vectors through a scoreboard plus game sequences.
module tb_grid_board_renderer;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] countH, countV;
   logic       move_left, move_right, move_up, move_down, select, clear;
   logic       vga_blank, vga_sync, mark_player, turn, illegal, board_full;
   logic [1:0] selector;
   logic [5:0] mark_x, mark_y;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         h;
      int         v;
      logic [1:0] sel;
      logic       blank;
      logic       player;
      int         mx;
      int         my;
   } pix_t;

   pix_t sb[$];
   pix_t vec[$];

   grid_board_renderer dut (
      .clk(clk), .rst(rst), .countH(countH), .countV(countV),
      .move_left(move_left), .move_right(move_right), .move_up(move_up),
      .move_down(move_down), .select(select), .clear(clear),
      .vga_blank(vga_blank), .vga_sync(vga_sync), .selector(selector),
      .mark_player(mark_player), .mark_x(mark_x), .mark_y(mark_y),
      .turn(turn), .illegal(illegal), .board_full(board_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic pix_t mk(input int h, input int v, input logic [1:0] sel,
                               input logic blank = 1'b1, input logic player = 1'b0,
                               input int mx = 0, input int my = 0);
      pix_t p;
      p.h = h; p.v = v; p.sel = sel; p.blank = blank;
      p.player = player; p.mx = mx; p.my = my;
      return p;
   endfunction

   task automatic compare_out();
      pix_t e;
      string tag;
      e   = sb.pop_front();
      tag = $sformatf("(%0d,%0d)", e.h, e.v);
      check({"selector ", tag}, 32'(selector), 32'(e.sel));
      check({"vga_blank ", tag}, 32'(vga_blank), 32'(e.blank));
      check({"vga_sync ", tag}, 32'(vga_sync), 32'(!e.blank));
      if (e.sel == 2'b11) begin
         check({"mark_player ", tag}, 32'(mark_player), 32'(e.player));
         check({"mark_x ", tag}, 32'(mark_x), 32'(e.mx));
         check({"mark_y ", tag}, 32'(mark_y), 32'(e.my));
      end
   endtask

   task automatic probe(input pix_t p);
      @(negedge clk);
      countH = 10'(p.h);
      countV = 10'(p.v);
      sb.push_back(p);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic run_vec();
      for (int i = 0; i < vec.size(); i++) probe(vec[i]);
      vec.delete();
   endtask

   task automatic pulse(input logic l, input logic r, input logic u, input logic d,
                        input logic s, input logic c);
      @(negedge clk);
      countH = 10'd1; countV = 10'd1;
      {move_left, move_right, move_up, move_down, select, clear} = {l, r, u, d, s, c};
      @(negedge clk);
      {move_left, move_right, move_up, move_down, select, clear} = '0;
   endtask

   task automatic frame(input logic exp_ill, input logic md = 1'b0);
      @(negedge clk);
      countH = 10'd0; countV = 10'd0;
      move_down = md;
      @(posedge clk);
      #1;
      check("illegal at frame start", 32'(illegal), 32'(exp_ill));
      @(negedge clk);
      countH = 10'd1; countV = 10'd1;
      move_down = 1'b0;
      @(posedge clk);
      #1;
      check("illegal after frame start", 32'(illegal), 32'd0);
   endtask

   int         cc, cr, mv;
   logic       exp_turn;
   logic [1:0] blink_exp;
   int         moves[8] = '{1, 3, 1, 1, 3, 0, 0, 4};  // 0 left,1 right,3 down,4 none

   initial begin
      rst = 1'b1;
      countH = 10'd100; countV = 10'd100;
      {move_left, move_right, move_up, move_down, select, clear} = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset vga_blank", 32'(vga_blank), 32'd0);
      check("reset vga_sync", 32'(vga_sync), 32'd1);
      check("reset selector", 32'(selector), 32'd1);
      check("reset mark_player", 32'(mark_player), 32'd0);
      check("reset mark_x", 32'(mark_x), 32'd0);
      check("reset mark_y", 32'(mark_y), 32'd0);
      check("reset turn", 32'(turn), 32'd0);
      check("reset illegal", 32'(illegal), 32'd0);
      check("reset board_full", 32'(board_full), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // empty board, cursor centred
      vec.push_back(mk(353, 100, 2'b10));
      vec.push_back(mk(100, 100, 2'b01, 1'b0));
      vec.push_back(mk(354, 200, 2'b10));
      vec.push_back(mk(400, 200, 2'b00));
      vec.push_back(mk(142,  35, 2'b00));
      vec.push_back(mk(781, 514, 2'b00));
      vec.push_back(mk(782, 200, 2'b01, 1'b0));
      vec.push_back(mk(400, 515, 2'b01, 1'b0));
      vec.push_back(mk(141, 200, 2'b01, 1'b0));
      vec.push_back(mk(200, 193, 2'b10));
      vec.push_back(mk(778, 100, 2'b00));
      vec.push_back(mk(777, 100, 2'b00));
      vec.push_back(mk(429, 243, 2'b00));
      vec.push_back(mk(563, 200, 2'b10));
      vec.push_back(mk(562, 200, 2'b00));
      vec.push_back(mk(400, 350, 2'b10));
      vec.push_back(mk(400, 349, 2'b00));
      vec.push_back(mk(565, 200, 2'b10));
      run_vec();

      // select mid-frame commits at frame start
      pulse(0, 0, 0, 0, 1, 0);
      check("turn before commit", 32'(turn), 32'd0);
      frame(1'b0);
      check("turn after select", 32'(turn), 32'd1);
      vec.push_back(mk(429, 243, 2'b11, 1'b1, 1'b0, 0, 0));
      vec.push_back(mk(489, 303, 2'b11, 1'b1, 1'b0, 60, 60));
      vec.push_back(mk(490, 243, 2'b00));
      vec.push_back(mk(429, 242, 2'b00));
      vec.push_back(mk(504, 243, 2'b00));
      run_vec();

      // left+right cancel
      pulse(1, 0, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 0, 0);
      frame(1'b0);
      vec.push_back(mk(354, 200, 2'b10));
      vec.push_back(mk(142, 200, 2'b00));
      run_vec();

      // up twice: row 1 -> 0 -> 2 (wrap)
      pulse(0, 0, 1, 0, 0, 0);
      frame(1'b0);
      vec.push_back(mk(354,  36, 2'b10));
      vec.push_back(mk(354, 200, 2'b00));
      run_vec();
      pulse(0, 0, 1, 0, 0, 0);
      frame(1'b0);
      vec.push_back(mk(354, 360, 2'b10));
      vec.push_back(mk(354,  36, 2'b00));
      run_vec();

      // down on the frame-start cycle lands one frame later (row 2 -> 0)
      frame(1'b0, 1'b1);
      vec.push_back(mk(354, 360, 2'b10));
      run_vec();
      frame(1'b0);
      vec.push_back(mk(354,  36, 2'b10));
      vec.push_back(mk(354, 360, 2'b00));
      run_vec();

      // back to (1,1), select occupied cell
      pulse(0, 0, 0, 1, 0, 0);
      frame(1'b0);
      pulse(0, 0, 0, 0, 1, 0);
      frame(1'b1);
      check("turn after illegal", 32'(turn), 32'd1);
      vec.push_back(mk(429, 243, 2'b11, 1'b1, 1'b0, 0, 0));
      run_vec();

      // fill remaining cells: select at the pre-move cursor, then move
      pulse(0, 1, 0, 0, 0, 0);
      frame(1'b0);
      cc = 2; cr = 1; exp_turn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mv = moves[i];
         check("board_full before last", 32'(board_full), 32'd0);
         pulse(mv == 0, mv == 1, 1'b0, mv == 3, 1'b1, 1'b0);
         frame(1'b0);
         probe(mk(217 + 212 * cc, 84 + 159 * cr, 2'b11, 1'b1, exp_turn, 0, 0));
         exp_turn = !exp_turn;
         check("turn during fill", 32'(turn), 32'(exp_turn));
         if (mv == 0) cc = (cc == 0) ? 2 : cc - 1;
         if (mv == 1) cc = (cc == 2) ? 0 : cc + 1;
         if (mv == 3) cr = (cr == 2) ? 0 : cr + 1;
      end
      check("board_full", 32'(board_full), 32'd1);
      vec.push_back(mk(641, 243, 2'b11, 1'b1, 1'b1, 0, 0));
      vec.push_back(mk(217,  84, 2'b11, 1'b1, 1'b0, 0, 0));
      run_vec();

      // clear mid-frame
      pulse(0, 0, 0, 0, 0, 1);
      check("turn after clear", 32'(turn), 32'd0);
      @(posedge clk);
      #1;
      check("board_full after clear", 32'(board_full), 32'd0);
      vec.push_back(mk(217,  84, 2'b00));
      vec.push_back(mk(354, 200, 2'b10));
      vec.push_back(mk(429, 243, 2'b00));
      vec.push_back(mk(641, 243, 2'b00));
      run_vec();

      // cursor visibility across 64 frames
      for (int f = 0; f < 64; f++) begin
`ifdef CURSOR_BLINK_EN
         blink_exp = (f < 32) ? 2'b10 : 2'b00;
`else
         blink_exp = 2'b10;
`endif
         probe(mk(354, 200, blink_exp));
         frame(1'b0);
      end

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
